// File: rtl/luces_kit_param_if.sv
// luces_kit_param_if: control inputs and LED/status outputs of the LED pattern kit
interface luces_kit_param_if #(
    parameter int N_LEDS = 16,
    parameter int N_VEL  = 8
);
    logic                     EN;
    logic [1:0]               MODE;
    logic                     VEL_UP;
    logic                     VEL_DOWN;
    logic [N_LEDS-1:0]        LEDS;
    logic [$clog2(N_VEL)-1:0] VEL;
    logic                     DIR;
    logic                     TICK;
    modport master (output EN, MODE, VEL_UP, VEL_DOWN, input LEDS, VEL, DIR, TICK);
    modport slave (input EN, MODE, VEL_UP, VEL_DOWN, output LEDS, VEL, DIR, TICK);
endinterface

// File: rtl/luces_kit_param.sv
// luces_kit_param: LED pattern generator (bounce/rotate/fill/blink) with button-driven speed
module luces_kit_param #(
    parameter int N_LEDS   = 16,
    parameter int N_VEL    = 8,
    parameter int BASE_DIV = 3125000
) (
    input logic CLK_50,
    input logic RST,
    luces_kit_param_if.slave io
);
    localparam int VW = $clog2(N_VEL);
    localparam int PW = $clog2(BASE_DIV * N_VEL + 1);
    logic [N_LEDS-1:0] leds_q, leds_d, leds_init, leds_step;
    logic              dir_q, dir_d, dir_step;
    logic              tick_q, tick_d;
    logic [VW-1:0]     vel_q, vel_d;
    logic [PW-1:0]     cnt_q, cnt_d, limit;
    logic [1:0]        mode_q, mode_d;
    logic              up_q, up_d, dn_q, dn_d, arm_q, arm_d;
    logic              up_p, dn_p, vel_chg, mode_chg, step;
    always_comb begin
        up_d      = io.VEL_UP;
        dn_d      = io.VEL_DOWN;
        arm_d     = 1'b1;
        // arm_q stays low for the first cycle after reset so a button held through release is not an edge
        up_p      = arm_q & io.VEL_UP & ~up_q;
        dn_p      = arm_q & io.VEL_DOWN & ~dn_q;
        vel_d     = (up_p && !dn_p && vel_q != VW'(N_VEL - 1)) ? vel_q + VW'(1) :
                    (dn_p && !up_p && vel_q != '0) ? vel_q - VW'(1) : vel_q;
        vel_chg   = vel_d != vel_q;
        mode_d    = io.MODE;
        mode_chg  = io.MODE != mode_q;
        limit     = PW'(BASE_DIV) * (PW'(N_VEL) - PW'(vel_q));
        step      = io.EN && !mode_chg && !vel_chg && cnt_q == limit - PW'(1);
        cnt_d     = (mode_chg || vel_chg || step) ? '0 : io.EN ? cnt_q + PW'(1) : cnt_q;
        tick_d    = step;
        leds_init = io.MODE[1] ? '0 : N_LEDS'(1);
        dir_step  = mode_q == 2'b00 ? (dir_q ? !leds_q[0] : leds_q[N_LEDS-1]) :
                    mode_q == 2'b10 ? (dir_q ? leds_q[0] : leds_q[N_LEDS-1]) : 1'b0;
        leds_step = mode_q == 2'b01 ? {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]} :
                    mode_q == 2'b11 ? {N_LEDS{~leds_q[0]}} :
                    dir_step ? leds_q >> 1 :
                    mode_q == 2'b10 ? {leds_q[N_LEDS-2:0], 1'b1} : leds_q << 1;
        leds_d    = mode_chg ? leds_init : step ? leds_step : leds_q;
        dir_d     = mode_chg ? 1'b0 : step ? dir_step : dir_q;
    end
    always_ff @(posedge CLK_50) begin
        if (RST) begin
            leds_q <= leds_init;
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
            vel_q  <= '0;
            cnt_q  <= '0;
            mode_q <= io.MODE;
            up_q   <= 1'b0;
            dn_q   <= 1'b0;
            arm_q  <= 1'b0;
        end else begin
            leds_q <= leds_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
            vel_q  <= vel_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            up_q   <= up_d;
            dn_q   <= dn_d;
            arm_q  <= arm_d;
        end
    end
    assign io.LEDS = leds_q;
    assign io.DIR  = dir_q;
    assign io.VEL  = vel_q;
    assign io.TICK = tick_q;
endmodule

// File: tb/tb_luces_kit_param.sv
// tb_luces_kit_param: vector-table bench for the LED pattern kit (N_LEDS=8, N_VEL=4, BASE_DIV=2)
module tb_luces_kit_param;
    localparam int NL = 8;
    localparam int NV = 4;
    localparam int BD = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    luces_kit_param_if #(.N_LEDS(NL), .N_VEL(NV)) io ();
    luces_kit_param #(.N_LEDS(NL), .N_VEL(NV), .BASE_DIV(BD)) dut (.CLK_50(clk), .RST(rst), .io(io));
    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic       en, up, dn;
        int         n;
        logic [7:0] leds;
        logic       dir;
        logic [1:0] vel;
        logic       tick;
    } vec_t;
    vec_t tab[$];
    int n_cmp = 0;
    int n_bad = 0;
    function automatic vec_t mk(logic r, logic [1:0] m, logic e, logic u, logic d, int n,
                                logic [7:0] l, logic di, logic [1:0] v, logic t);
        vec_t x;
        x.rst = r; x.mode = m; x.en = e; x.up = u; x.dn = d; x.n = n;
        x.leds = l; x.dir = di; x.vel = v; x.tick = t;
        return x;
    endfunction
    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic period(input int exp, input int idx);
        int c = 0;
        while (!io.TICK && c < 64) begin
            cyc(1);
            c++;
        end
        c = 0;
        do begin
            cyc(1);
            c++;
        end while (!io.TICK && c < 64);
        chk("tick_period", idx, 32'(c), 32'(exp));
    endtask
    task automatic pulse_up();
        io.VEL_UP = 1'b1;
        cyc(1);
        io.VEL_UP = 1'b0;
        cyc(1);
    endtask
    initial begin
        io.EN = 1'b0; io.MODE = 2'b00; io.VEL_UP = 1'b0; io.VEL_DOWN = 1'b0;
        // reset, then bounce at VEL=0: one step per 8 cycles
        tab.push_back(mk(1, 2'b00, 0, 0, 0, 2, 8'h01, 0, 0, 0));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h02, 0, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h04, 0, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h08, 0, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h10, 0, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h20, 0, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h40, 0, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h80, 0, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h40, 1, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h20, 1, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h10, 1, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h08, 1, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h04, 1, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h02, 1, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h01, 1, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h02, 0, 0, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 7, 8'h02, 0, 0, 0));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 1, 8'h04, 0, 0, 1));
        // EN=0 freeze mid-count: prescaler resumes from 3
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 3, 8'h04, 0, 0, 0));
        tab.push_back(mk(0, 2'b00, 0, 0, 0, 50, 8'h04, 0, 0, 0));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 4, 8'h04, 0, 0, 0));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 1, 8'h08, 0, 0, 1));
        // five VEL_UP pulses with EN=0, saturating at 3
        for (int i = 0; i < 5; i++) begin
            tab.push_back(mk(0, 2'b00, 0, 1, 0, 1, 8'h08, 0, 2'(i < 3 ? i + 1 : 3), 0));
            tab.push_back(mk(0, 2'b00, 0, 0, 0, 1, 8'h08, 0, 2'(i < 3 ? i + 1 : 3), 0));
        end
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 1, 8'h08, 0, 3, 0));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 1, 8'h10, 0, 3, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 1, 8'h10, 0, 3, 0));
        tab.push_back(mk(0, 2'b00, 1, 1, 0, 1, 8'h20, 0, 3, 1));
        // down steps, simultaneous edges, held button
        tab.push_back(mk(0, 2'b00, 0, 0, 0, 1, 8'h20, 0, 3, 0));
        tab.push_back(mk(0, 2'b00, 0, 0, 1, 1, 8'h20, 0, 2, 0));
        tab.push_back(mk(0, 2'b00, 0, 0, 0, 1, 8'h20, 0, 2, 0));
        tab.push_back(mk(0, 2'b00, 0, 0, 1, 1, 8'h20, 0, 1, 0));
        tab.push_back(mk(0, 2'b00, 0, 0, 0, 1, 8'h20, 0, 1, 0));
        tab.push_back(mk(0, 2'b00, 0, 1, 1, 1, 8'h20, 0, 1, 0));
        tab.push_back(mk(0, 2'b00, 0, 0, 0, 1, 8'h20, 0, 1, 0));
        tab.push_back(mk(0, 2'b00, 0, 1, 0, 20, 8'h20, 0, 2, 0));
        tab.push_back(mk(0, 2'b00, 0, 0, 0, 1, 8'h20, 0, 2, 0));
        // VEL=2 -> 4 cycles per step, then reset mid-bounce
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 4, 8'h40, 0, 2, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 4, 8'h80, 0, 2, 1));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 2, 8'h80, 0, 2, 0));
        tab.push_back(mk(1, 2'b00, 1, 0, 0, 1, 8'h01, 0, 0, 0));
        // button held through reset release gives no step
        tab.push_back(mk(1, 2'b00, 0, 1, 0, 2, 8'h01, 0, 0, 0));
        tab.push_back(mk(0, 2'b00, 0, 1, 0, 3, 8'h01, 0, 0, 0));
        tab.push_back(mk(0, 2'b00, 0, 0, 0, 1, 8'h01, 0, 0, 0));
        tab.push_back(mk(0, 2'b00, 0, 1, 0, 1, 8'h01, 0, 1, 0));
        tab.push_back(mk(0, 2'b00, 0, 0, 1, 1, 8'h01, 0, 0, 0));
        tab.push_back(mk(0, 2'b00, 0, 0, 0, 1, 8'h01, 0, 0, 0));
        // mode change while EN=0, then rotate with wrap
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h02, 0, 0, 1));
        tab.push_back(mk(0, 2'b01, 0, 0, 0, 1, 8'h01, 0, 0, 0));
        tab.push_back(mk(0, 2'b01, 1, 0, 0, 56, 8'h80, 0, 0, 1));
        tab.push_back(mk(0, 2'b01, 1, 0, 0, 8, 8'h01, 0, 0, 1));
        // fill bar
        tab.push_back(mk(0, 2'b10, 1, 0, 0, 1, 8'h00, 0, 0, 0));
        tab.push_back(mk(0, 2'b10, 1, 0, 0, 8, 8'h01, 0, 0, 1));
        tab.push_back(mk(0, 2'b10, 1, 0, 0, 8, 8'h03, 0, 0, 1));
        tab.push_back(mk(0, 2'b10, 1, 0, 0, 8, 8'h07, 0, 0, 1));
        tab.push_back(mk(0, 2'b10, 1, 0, 0, 40, 8'hFF, 0, 0, 1));
        tab.push_back(mk(0, 2'b10, 1, 0, 0, 8, 8'h7F, 1, 0, 1));
        tab.push_back(mk(0, 2'b10, 1, 0, 0, 8, 8'h3F, 1, 0, 1));
        tab.push_back(mk(0, 2'b10, 1, 0, 0, 48, 8'h00, 1, 0, 1));
        tab.push_back(mk(0, 2'b10, 1, 0, 0, 8, 8'h01, 0, 0, 1));
        tab.push_back(mk(0, 2'b10, 1, 0, 0, 3, 8'h01, 0, 0, 0));
        // blink, switched mid-sequence
        tab.push_back(mk(0, 2'b11, 1, 0, 0, 1, 8'h00, 0, 0, 0));
        tab.push_back(mk(0, 2'b11, 1, 0, 0, 8, 8'hFF, 0, 0, 1));
        tab.push_back(mk(0, 2'b11, 1, 0, 0, 8, 8'h00, 0, 0, 1));
        tab.push_back(mk(0, 2'b11, 1, 0, 0, 7, 8'h00, 0, 0, 0));
        tab.push_back(mk(0, 2'b11, 1, 0, 0, 1, 8'hFF, 0, 0, 1));
        // reset wins over a concurrent mode change; registered mode loads so no spurious clear after
        tab.push_back(mk(1, 2'b00, 1, 0, 0, 1, 8'h01, 0, 0, 0));
        tab.push_back(mk(0, 2'b00, 1, 0, 0, 8, 8'h02, 0, 0, 1));
        foreach (tab[i]) begin
            rst = tab[i].rst;
            io.MODE = tab[i].mode;
            io.EN = tab[i].en;
            io.VEL_UP = tab[i].up;
            io.VEL_DOWN = tab[i].dn;
            cyc(tab[i].n);
            chk("leds", i, 32'(io.LEDS), 32'(tab[i].leds));
            chk("dir", i, 32'(io.DIR), 32'(tab[i].dir));
            chk("vel", i, 32'(io.VEL), 32'(tab[i].vel));
            chk("tick", i, 32'(io.TICK), 32'(tab[i].tick));
        end
        io.VEL_UP = 1'b0;
        io.VEL_DOWN = 1'b0;
        period(8, 1000);
        repeat (3) pulse_up();
        chk("vel_after_pulses", 1001, 32'(io.VEL), 32'd3);
        period(2, 1002);
        period(2, 1003);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/luces_kit_param.md
LUCES_KIT_PARAM -- requirements
Module: luces_kit_param

Interface
REQ-001 Parameter N_LEDS, default 16: number of LED outputs; legal range 4..32.
REQ-002 Parameter N_VEL, default 8: number of speed levels; legal range 2..16.
REQ-003 Parameter BASE_DIV, default 3125000: CLK_50 cycles per step unit; must be at least 1.
REQ-004 CLK_50  input  1  system clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset; synchronous, active-high.
REQ-006 EN  input  1  level; 1 = pattern advances, 0 = pattern and prescaler freeze.
REQ-007 MODE  input  2  pattern select: 00 bounce, 01 rotate, 10 fill bar, 11 blink.
REQ-008 VEL_UP  input  1  raw level, active-high; each rising edge requests one step faster.
REQ-009 VEL_DOWN  input  1  raw level, active-high; each rising edge requests one step slower.
REQ-010 LEDS  output  N_LEDS  registered LED pattern.
REQ-011 VEL  output  clog2(N_VEL)  current speed level; 0 is slowest.
REQ-012 DIR  output  1  registered direction: 0 = up/left, 1 = down/right.
REQ-013 TICK  output  1  registered one-cycle pulse on each pattern step.

Function
REQ-014 Edge detect: one registered stage per button; pulse = current high and previous low; a held button gives exactly one step.
REQ-015 Speed: up pulse gives VEL+1 and saturates at N_VEL-1; down pulse gives VEL-1 and saturates at 0.
REQ-016 Speed, simultaneous events: up and down pulses in the same cycle leave VEL unchanged.
REQ-017 Speed change: any actual VEL change clears the prescaler the following cycle; a saturated request does not clear it.
REQ-018 Prescaler: counts 0..LIMIT-1 while EN=1, with LIMIT = BASE_DIV*(N_VEL-VEL).
REQ-019 Prescaler width: sized for BASE_DIV*N_VEL without overflow.
REQ-020 Step event: the prescaler wraps from LIMIT-1 to 0; pattern update and TICK=1 occur in that same cycle.
REQ-021 EN=0: prescaler, LEDS, DIR and TICK=0 all hold; speed buttons still take effect.
REQ-022 Bounce mode: a single LED moves one position per step.
REQ-023 Bounce, DIR=0: if LEDS[N_LEDS-1]=1, set DIR=1 and shift right; else shift left.
REQ-024 Bounce, DIR=1: if LEDS[0]=1, set DIR=0 and shift left; else shift right.
REQ-025 Bounce period: 2*(N_LEDS-1) steps; each end LED is lit for exactly one step per visit.
REQ-026 Rotate mode: a single LED rotates left; MSB wraps to bit 0; DIR is held at 0.
REQ-027 Fill mode: LEDS is a thermometer code (2^k)-1 with k in 0..N_LEDS.
REQ-028 Fill, DIR=0: k increments; at k=N_LEDS it sets DIR=1 and decrements instead.
REQ-029 Fill, DIR=1: k decrements; at k=0 it sets DIR=0 and increments instead.
REQ-030 Blink mode: LEDS toggles between all-zero and all-one each step; DIR is held at 0.
REQ-031 Mode change: a MODE value differing from the previous cycle's registered value loads the new mode's initial pattern next cycle and clears the prescaler.
REQ-032 Mode change takes effect regardless of EN.
REQ-033 Initial patterns: bounce/rotate LEDS=1 and DIR=0; fill LEDS=0 and DIR=0; blink LEDS=0 and DIR=0.
REQ-034 Pattern invariant: LEDS is never all-zero in bounce or rotate mode.

Reset
REQ-035 RST=1 at a clock edge sets: LEDS to the initial pattern of the current MODE; DIR=0; VEL=0; TICK=0; prescaler=0; edge-detect history=0; registered MODE=MODE.
REQ-036 RST has priority over every other input, including mid-step and mid-mode-change.
REQ-037 Button inputs held high through reset release do not generate a step.

Verification (N_LEDS=8, N_VEL=4, BASE_DIV=2)
REQ-038 Reset with MODE=00, then EN=1 -> TICK every 8 cycles.
REQ-039 Same setup -> LEDS sequence 01,02,04,...,80,40,...,01,02; DIR goes to 1 at the step leaving 80 and to 0 at the step leaving 01.
REQ-040 VEL_UP pulsed 5 times (each one cycle high, one cycle low) -> VEL=3 (saturated); TICK period = 2 cycles.
REQ-041 VEL_UP held high 20 cycles -> VEL increments by exactly 1.
REQ-042 VEL_UP and VEL_DOWN rising together -> VEL unchanged.
REQ-043 MODE=10 -> LEDS 00,01,03,...,FF,7F,...,00,01.
REQ-044 Switch to MODE=11 mid-sequence -> LEDS=00 next cycle, then toggling FF/00 every LIMIT cycles.
REQ-045 EN=0 for 50 cycles mid-bounce -> LEDS, DIR and prescaler frozen, TICK=0.
REQ-046 RST=1 mid-bounce with VEL=2 -> next cycle LEDS=01, VEL=0, DIR=0.
